// File: rtl/id_pipe_stage.sv
// Instruction-decode stage with ID/EX pipeline register.
// Decodes the supported I-type and R-type instructions, forwards operands
// from EX and MEM, stalls on load-use hazards, and honours EX backpressure
// and flush.
module id_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int OPER_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_inst,
   input  logic [31:0]       if_pc,
   output logic              id_ready,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic              fwd_ex_wen,
   input  logic [REG_AW-1:0] fwd_ex_waddr,
   input  logic [DATA_W-1:0] fwd_ex_wdata,
   input  logic              fwd_ex_load,
   input  logic              fwd_mem_wen,
   input  logic [REG_AW-1:0] fwd_mem_waddr,
   input  logic [DATA_W-1:0] fwd_mem_wdata,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [OPER_W-1:0] ex_oper,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic              ex_wen,
   output logic [REG_AW-1:0] ex_waddr,
   output logic [31:0]       ex_pc,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [OPER_W-1:0] {
      OPER_NOP  = OPER_W'(0),
      OPER_OR   = OPER_W'(1),
      OPER_AND  = OPER_W'(2),
      OPER_XOR  = OPER_W'(3),
      OPER_ADDU = OPER_W'(4),
      OPER_SLL  = OPER_W'(5),
      OPER_LUI  = OPER_W'(6),
      OPER_LW   = OPER_W'(7)
   } oper_e;

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [4:0]        shamt;
   logic [15:0]       imm;

   assign opcode = if_inst[31:26];
   assign rs     = REG_AW'(if_inst[25:21]);
   assign rt     = REG_AW'(if_inst[20:16]);
   assign rd     = REG_AW'(if_inst[15:11]);
   assign shamt  = if_inst[10:6];
   assign funct  = if_inst[5:0];
   assign imm    = if_inst[15:0];

   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;

   // Operand source: r0 -> 0, then non-load EX result, then MEM result, then regfile
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_AW-1:0] a,
      input logic [DATA_W-1:0] rf_d,
      input logic              ex_w,
      input logic              ex_ld,
      input logic [REG_AW-1:0] ex_a,
      input logic [DATA_W-1:0] ex_d,
      input logic              mem_w,
      input logic [REG_AW-1:0] mem_a,
      input logic [DATA_W-1:0] mem_d
   );
      if (a == '0)
         return '0;
      else if (ex_w && !ex_ld && (ex_a == a))
         return ex_d;
      else if (mem_w && (mem_a == a))
         return mem_d;
      else
         return rf_d;
   endfunction

   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;

   assign src1 = fwd_sel(rs, rf_rdata1, fwd_ex_wen, fwd_ex_load, fwd_ex_waddr,
                         fwd_ex_wdata, fwd_mem_wen, fwd_mem_waddr, fwd_mem_wdata);
   assign src2 = fwd_sel(rt, rf_rdata2, fwd_ex_wen, fwd_ex_load, fwd_ex_waddr,
                         fwd_ex_wdata, fwd_mem_wen, fwd_mem_waddr, fwd_mem_wdata);

   oper_e             dec_oper;
   logic [DATA_W-1:0] dec_op1;
   logic [DATA_W-1:0] dec_op2;
   logic              dec_wen_raw;
   logic              dec_wen;
   logic [REG_AW-1:0] dec_waddr;
   logic              uses_rs;
   logic              uses_rt;

   // Instruction decode: operation, operands, destination and registers read
   always_comb begin
      dec_oper    = OPER_NOP;
      dec_op1     = '0;
      dec_op2     = '0;
      dec_wen_raw = 1'b0;
      dec_waddr   = '0;
      uses_rs     = 1'b0;
      uses_rt     = 1'b0;
      unique case (opcode)
         6'h0D, 6'h0C, 6'h0E: begin
            dec_oper    = (opcode == 6'h0D) ? OPER_OR :
                          (opcode == 6'h0C) ? OPER_AND : OPER_XOR;
            dec_op1     = src1;
            dec_op2     = DATA_W'(imm);
            dec_wen_raw = 1'b1;
            dec_waddr   = rt;
            uses_rs     = 1'b1;
         end
         6'h09, 6'h23: begin
            dec_oper    = (opcode == 6'h09) ? OPER_ADDU : OPER_LW;
            dec_op1     = src1;
            dec_op2     = DATA_W'(signed'(imm));
            dec_wen_raw = 1'b1;
            dec_waddr   = rt;
            uses_rs     = 1'b1;
         end
         6'h0F: begin
            dec_oper    = OPER_LUI;
            dec_op2     = DATA_W'({imm, 16'h0000});
            dec_wen_raw = 1'b1;
            dec_waddr   = rt;
         end
         6'h00: begin
            unique case (funct)
               6'h25, 6'h24, 6'h26, 6'h21: begin
                  dec_oper    = (funct == 6'h25) ? OPER_OR  :
                                (funct == 6'h24) ? OPER_AND :
                                (funct == 6'h26) ? OPER_XOR : OPER_ADDU;
                  dec_op1     = src1;
                  dec_op2     = src2;
                  dec_wen_raw = 1'b1;
                  dec_waddr   = rd;
                  uses_rs     = 1'b1;
                  uses_rt     = 1'b1;
               end
               6'h00: begin
                  dec_oper    = OPER_SLL;
                  dec_op1     = DATA_W'(shamt);
                  dec_op2     = src2;
                  dec_wen_raw = 1'b1;
                  dec_waddr   = rd;
                  uses_rt     = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign dec_wen = dec_wen_raw && (dec_waddr != '0);

   logic stall;
   logic space;
   logic accept;

   assign stall = if_valid && fwd_ex_wen && fwd_ex_load && (fwd_ex_waddr != '0) &&
                  ((uses_rs && (fwd_ex_waddr == rs)) || (uses_rt && (fwd_ex_waddr == rt)));
   assign space    = !ex_valid || ex_ready;
   assign id_ready = !stall && space && !flush;
   assign accept   = if_valid && !stall;

   // ID/EX register: flush kills, free slot loads or bubbles, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_oper  <= OPER_NOP;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_wen   <= 1'b0;
         ex_waddr <= '0;
         ex_pc    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (space) begin
         if (accept) begin
            ex_valid <= 1'b1;
            ex_oper  <= dec_oper;
            ex_op1   <= dec_op1;
            ex_op2   <= dec_op2;
            ex_wen   <= dec_wen;
            ex_waddr <= dec_waddr;
            ex_pc    <= if_pc;
         end else begin
            ex_valid <= 1'b0;
         end
      end
   end

   // Saturating count of load-use stall cycles not overridden by flush
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the decode stage.
module tb_id_pipe_stage;

   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        fwd_ex_wen, fwd_ex_load;
   logic [4:0]  fwd_ex_waddr;
   logic [31:0] fwd_ex_wdata;
   logic        fwd_mem_wen;
   logic [4:0]  fwd_mem_waddr;
   logic [31:0] fwd_mem_wdata;
   logic        flush, ex_ready;
   logic        ex_valid, ex_wen;
   logic [3:0]  ex_oper;
   logic [31:0] ex_op1, ex_op2, ex_pc;
   logic [4:0]  ex_waddr;
   logic [CW-1:0] stall_cnt;

   logic [31:0] regs [32];

   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   id_pipe_stage #(.DATA_W(32), .REG_AW(5), .OPER_W(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .id_ready(id_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_ex_wen(fwd_ex_wen), .fwd_ex_waddr(fwd_ex_waddr), .fwd_ex_wdata(fwd_ex_wdata),
      .fwd_ex_load(fwd_ex_load), .fwd_mem_wen(fwd_mem_wen), .fwd_mem_waddr(fwd_mem_waddr),
      .fwd_mem_wdata(fwd_mem_wdata), .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_oper(ex_oper), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_pc(ex_pc), .stall_cnt(stall_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model of the ID/EX register contents
   bit          m_valid = 0;
   int          m_oper  = 0;
   logic [31:0] m_op1 = 0, m_op2 = 0, m_pc = 0;
   bit          m_wen = 0;
   logic [4:0]  m_waddr = 0;
   int          m_cnt = 0;
   bit          m_full = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] itype(input int opc, input int rs, input int rt, input int imm);
      return {opc[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (fwd_ex_wen && !fwd_ex_load && fwd_ex_waddr == a) return fwd_ex_wdata;
      if (fwd_mem_wen && fwd_mem_waddr == a) return fwd_mem_wdata;
      return regs[a];
   endfunction

   // One clock: check the combinational outputs, advance the model, check the register
   task automatic step();
      logic [31:0] inst;
      int opc, fn, rs, rt, rd, sh, imm;
      int oper;
      bit urs, urt, wen, stall, space, acc;
      int wa;
      logic [31:0] a, b;
      #3;
      inst = if_inst;
      opc = int'(inst[31:26]); rs = int'(inst[25:21]); rt = int'(inst[20:16]);
      rd  = int'(inst[15:11]); sh = int'(inst[10:6]);  fn = int'(inst[5:0]);
      imm = int'(inst[15:0]);
      oper = 0; urs = 0; urt = 0; wen = 0; wa = 0; a = 0; b = 0;
      if (opc == 'h0D || opc == 'h0C || opc == 'h0E) begin
         oper = (opc == 'h0D) ? 1 : (opc == 'h0C) ? 2 : 3;
         urs = 1; wen = 1; wa = rt; a = operand(5'(rs)); b = imm;
      end else if (opc == 'h09 || opc == 'h23) begin
         oper = (opc == 'h09) ? 4 : 7;
         urs = 1; wen = 1; wa = rt; a = operand(5'(rs));
         b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
      end else if (opc == 'h0F) begin
         oper = 6; wen = 1; wa = rt; a = 0; b = 32'(imm * 65536);
      end else if (opc == 0 && (fn == 'h25 || fn == 'h24 || fn == 'h26 || fn == 'h21)) begin
         oper = (fn == 'h25) ? 1 : (fn == 'h24) ? 2 : (fn == 'h26) ? 3 : 4;
         urs = 1; urt = 1; wen = 1; wa = rd; a = operand(5'(rs)); b = operand(5'(rt));
      end else if (opc == 0 && fn == 0) begin
         oper = 5; urt = 1; wen = 1; wa = rd; a = sh; b = operand(5'(rt));
      end
      if (wa == 0) wen = 0;

      stall = if_valid && fwd_ex_wen && fwd_ex_load && fwd_ex_waddr != 0 &&
              ((urs && fwd_ex_waddr == 5'(rs)) || (urt && fwd_ex_waddr == 5'(rt)));
      space = !m_valid || ex_ready;
      acc   = if_valid && !stall && !flush && space;
      check("id_ready", 32'(id_ready), 32'(!stall && space && !flush));
      check("rf_raddr1", 32'(rf_raddr1), 32'(rs));
      check("rf_raddr2", 32'(rf_raddr2), 32'(rt));

      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 0; m_oper = 0; m_op1 = 0; m_op2 = 0; m_wen = 0; m_waddr = 0;
         m_pc = 0; m_cnt = 0; m_full = 1;
      end else begin
         m_full = 0;
         if (stall && !flush && m_cnt < CNT_MAX) m_cnt++;
         if (flush) m_valid = 0;
         else if (space) begin
            if (acc) begin
               m_valid = 1; m_oper = oper; m_op1 = a; m_op2 = b;
               m_wen = wen; m_waddr = 5'(wa); m_pc = if_pc;
            end else begin
               m_valid = 0;
            end
         end
      end
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (m_valid || m_full) begin
         check("ex_oper", 32'(ex_oper), 32'(m_oper));
         check("ex_wen", 32'(ex_wen), 32'(m_wen));
         check("ex_pc", ex_pc, m_pc);
      end
      if (m_full || (m_valid && m_oper != 0)) begin
         check("ex_op1", ex_op1, m_op1);
         check("ex_op2", ex_op2, m_op2);
         check("ex_waddr", 32'(ex_waddr), 32'(m_waddr));
      end
   endtask

   task automatic rand_inputs();
      int sel;
      logic [31:0] tmp;
      int opcs [10] = '{'h0D, 'h0C, 'h0E, 'h09, 'h23, 'h0F, 0, 0, 0, 0};
      int fns  [5]  = '{'h25, 'h24, 'h26, 'h21, 'h00};
      sel = int'($urandom_range(0, 10));
      tmp = $urandom;
      if (sel == 10)
         if_inst = tmp;
      else if (opcs[sel] == 0)
         if_inst = rtype(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                     : fns[$urandom_range(0, 4)]);
      else
         if_inst = itype(opcs[sel], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'(tmp[15:0]));
      if_valid      = ($urandom_range(0, 4) != 0);
      if_pc         = $urandom;
      fwd_ex_wen    = $urandom_range(0, 1) == 1;
      fwd_ex_load   = $urandom_range(0, 2) == 0;
      fwd_ex_waddr  = 5'($urandom_range(0, 7));
      fwd_ex_wdata  = $urandom;
      fwd_mem_wen   = $urandom_range(0, 1) == 1;
      fwd_mem_waddr = 5'($urandom_range(0, 7));
      fwd_mem_wdata = $urandom;
      ex_ready      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      regs[$urandom_range(0, 31)] = $urandom;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rst = 1; if_valid = 0; if_inst = 0; if_pc = 0;
      fwd_ex_wen = 0; fwd_ex_waddr = 0; fwd_ex_wdata = 0; fwd_ex_load = 0;
      fwd_mem_wen = 0; fwd_mem_waddr = 0; fwd_mem_wdata = 0;
      flush = 0; ex_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      step();                                     // reset values
      rst = 0;

      // ORI r2,r1,0xF0F0
      regs[1] = 32'h0000_1200;
      if_valid = 1; if_pc = 32'h100; if_inst = itype('h0D, 1, 2, 'hF0F0);
      step();
      check("ori_op1", ex_op1, 32'h0000_1200);
      check("ori_op2", ex_op2, 32'h0000_F0F0);

      // ADDU r3,r1,r2 with EX and MEM both targeting r1
      if_inst = rtype(1, 2, 3, 0, 'h21); if_pc = 32'h104;
      fwd_ex_wen = 1; fwd_ex_waddr = 1; fwd_ex_wdata = 32'hAA;
      fwd_mem_wen = 1; fwd_mem_waddr = 1; fwd_mem_wdata = 32'hBB;
      step();
      check("fwd_ex_op1", ex_op1, 32'hAA);
      fwd_ex_wen = 0;
      step();
      check("fwd_mem_op1", ex_op1, 32'hBB);
      fwd_mem_wen = 0;
      if_inst = itype('h0D, 1, 0, 'h1234);
      step();
      check("r0_dest_wen", 32'(ex_wen), 32'h0);

      // load-use: LW r4 in EX, then ADDIU r5,r4,-1
      fwd_ex_wen = 1; fwd_ex_load = 1; fwd_ex_waddr = 4;
      if_inst = itype('h09, 4, 5, 'hFFFF); if_pc = 32'h10C;
      step();
      check("lu_bubble", 32'(ex_valid), 32'h0);
      check("lu_cnt", 32'(stall_cnt), 32'h1);
      fwd_ex_wen = 0; fwd_ex_load = 0;
      fwd_mem_wen = 1; fwd_mem_waddr = 4; fwd_mem_wdata = 32'h77;
      step();
      check("lu_op2", ex_op2, 32'hFFFF_FFFF);
      fwd_mem_wen = 0;

      // backpressure: hold for 3 cycles with a new instruction waiting
      ex_ready = 0; if_inst = itype('h0E, 2, 6, 'h00FF); if_pc = 32'h200;
      repeat (3) step();
      check("bp_hold_pc", ex_pc, 32'h10C);
      ex_ready = 1;
      step();
      check("bp_load_pc", ex_pc, 32'h200);

      // flush with valid contents and a valid incoming instruction
      flush = 1; if_pc = 32'h204;
      step();
      check("flush_valid", 32'(ex_valid), 32'h0);
      flush = 0;

      // stall counter saturation
      fwd_ex_wen = 1; fwd_ex_load = 1; fwd_ex_waddr = 3;
      if_inst = rtype(1, 3, 7, 0, 'h25);
      repeat (CNT_MAX + 5) step();
      check("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
      fwd_ex_wen = 0; fwd_ex_load = 0;
      step();

      // reset mid-stream
      rst = 1;
      step();
      check("rst_cnt", 32'(stall_cnt), 32'h0);
      rst = 0;

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
